bcd_event_counter: RTL

Parametrised multi-channel BCD event counter for the game's on-screen tallies (deaths, hits, pickups per player). Each channel counts rising occurrences of a level-sensitive event, sampled once per frame, and holds until the event deasserts. DIGITS-wide BCD values feed the score/HUD text renderer directly, plus a per-channel overflow pulse and a registered "leader" index for the UI highlight.

---
 rtl/bcd_pkg.sv | 43 ++++
 rtl/bcd_channel_counter.sv | 88 ++++++++
 rtl/bcd_event_counter.sv | 74 +++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the on-screen tally counters.
// Holds the per-channel FSM state encoding and digit-level arithmetic and compare.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE   = 4'd9;
  localparam int         MAX_DIGITS = 8;
  localparam int         BCD_VEC_W  = MAX_DIGITS * 4;

  typedef enum logic {
    ARMED = 1'b0,
    HELD  = 1'b1
  } chan_state_t;

  // Single-digit increment; returns {carry, digit}.
  function automatic logic [4:0] bcd_inc(input bcd_digit_t digit);
    logic [4:0] result;
    if (digit == BCD_NINE) begin
      result = {1'b1, 4'd0};
    end else begin
      result = {1'b0, digit + 4'd1};
    end
    return result;
  endfunction

  // Greater-than over a zero-extended BCD vector, most-significant digit first.
  function automatic logic bcd_gt(input logic [BCD_VEC_W-1:0] a,
                                  input logic [BCD_VEC_W-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_channel_counter.sv
// One tally channel: ARMED/HELD edge-qualifying FSM, DIGITS-wide BCD count, overflow pulse.
// Build option BCD_SATURATE_EN: hold at all-9s instead of wrapping to zero.
module bcd_channel_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  clear_i,
  input  logic                  strobe_i,
  input  logic                  event_i,
  output logic [DIGITS*4-1:0]   count_o,
  output logic                  overflow_o
);

  chan_state_t          state_q, state_d;
  logic [DIGITS*4-1:0]  count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [DIGITS*4-1:0]  sum;
  logic                 carry;
  logic                 inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    inc        = 1'b0;

    if (strobe_i) begin
      unique case (state_q)
        ARMED: begin
          if (event_i) begin
            inc     = 1'b1;
            state_d = HELD;
          end
        end
        HELD: begin
          if (!event_i) begin
            state_d = ARMED;
          end
        end
        default: state_d = ARMED;
      endcase
    end

    // Ripple carry from the ones digit; a carry out of the top digit means all-9s.
    sum   = count_q;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      {carry, sum[d*4 +: 4]} = carry ? bcd_inc(count_q[d*4 +: 4])
                                     : {1'b0, count_q[d*4 +: 4]};
    end

    if (inc) begin
      overflow_d = carry;
`ifdef BCD_SATURATE_EN
      count_d = carry ? count_q : sum;
`else
      count_d = sum;
`endif
    end

    // Round restart zeroes the tally but leaves the FSM free to move, so a held event stays held.
    if (clear_i) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ARMED;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-channel BCD event counter for HUD tallies: frame strobe, CHANNELS counters, leader index.
// Build option BCD_SATURATE_EN selects saturating instead of wrapping counters.
module bcd_event_counter
  import bcd_pkg::*;
#(
  parameter  int DIGITS   = 2,
  parameter  int CHANNELS = 2,
  localparam int LW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk,
  input  logic                          clear,
  input  logic [CHANNELS-1:0]           event_in,
  output logic [CHANNELS*DIGITS*4-1:0]  count,
  output logic [CHANNELS-1:0]           overflow,
  output logic [LW-1:0]                 leader
);

  localparam int CW = DIGITS * 4;

  logic               frame_dly_q;
  logic               strobe_q;
  logic [LW-1:0]      leader_q, leader_d;
  logic [BCD_VEC_W-1:0] best_val;

  // Rising-edge detect of the frame tick; clear deliberately does not touch this pipeline.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_dly_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      frame_dly_q <= frame_clk;
      strobe_q    <= frame_clk & ~frame_dly_q;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    bcd_channel_counter #(
      .DIGITS (DIGITS)
    ) u_chan (
      .Clk        (Clk),
      .Reset      (Reset),
      .clear_i    (clear),
      .strobe_i   (strobe_q),
      .event_i    (event_in[c]),
      .count_o    (count[c*CW +: CW]),
      .overflow_o (overflow[c])
    );
  end

  // Strict greater-than while scanning upward keeps ties (and all-zero) on the lowest index.
  always_comb begin
    leader_d = '0;
    best_val = BCD_VEC_W'(count[CW-1:0]);
    for (int c = 1; c < CHANNELS; c++) begin
      if (bcd_gt(BCD_VEC_W'(count[c*CW +: CW]), best_val)) begin
        leader_d = LW'(c);
        best_val = BCD_VEC_W'(count[c*CW +: CW]);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      leader_q <= '0;
    end else begin
      leader_q <= leader_d;
    end
  end

  assign leader = leader_q;

endmodule
